// File: rtl/cpu_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_decode_if
// Brief    : Upstream fetch, register-file and downstream ALU bundle signals
//            of the RV32I decode stage.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_decode_if #(
    parameter int XLEN = 32
) ();
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_pc;
    logic [4:0]      o_rs1_addr;
    logic [4:0]      o_rs2_addr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [3:0]      o_op;
    logic [XLEN-1:0] o_a;
    logic [XLEN-1:0] o_b;
    logic [4:0]      o_rd_addr;
    logic            o_rd_we;
    logic [XLEN-1:0] o_pc;
    logic            o_illegal;

    // Decode-stage view
    modport slave (
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
        output o_ready, o_rs1_addr, o_rs2_addr, o_valid, o_op, o_a, o_b,
               o_rd_addr, o_rd_we, o_pc, o_illegal
    );

    // Surrounding pipeline view
    modport master (
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
        input  o_ready, o_rs1_addr, o_rs2_addr, o_valid, o_op, o_a, o_b,
               o_rd_addr, o_rd_we, o_pc, o_illegal
    );
endinterface
`default_nettype wire

// File: rtl/cpu_decode.sv
`default_nettype none
// ============================================================================
// Module   : cpu_decode
// Brief    : RV32I decode stage for OP/OP-IMM/LUI/AUIPC feeding the ALU.
//            Define CPU_DECODE_SKID_EN for a registered o_ready skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_decode #(
    parameter int XLEN = 32
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst,
    cpu_decode_if.slave bus
);
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_f7_zero    = 7'b0000000;
    localparam logic [6:0] c_f7_alt     = 7'b0100000;
    localparam logic [3:0] c_alu_add    = 4'b0000;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd_addr;
        logic            rd_we;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic            w_is_shift;
    logic            w_legal;
    bundle_t         w_dec;
    bundle_t         r_main;
    logic            r_main_valid;
    logic            w_ready;
    logic            w_accept;

    assign w_opcode   = bus.i_instr[6:0];
    assign w_rd       = bus.i_instr[11:7];
    assign w_funct3   = bus.i_instr[14:12];
    assign w_funct7   = bus.i_instr[31:25];
    assign w_imm_i    = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:20]};
    assign w_imm_u    = {bus.i_instr[31:12], 12'b0};
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    assign bus.o_rs1_addr = bus.i_instr[19:15];
    assign bus.o_rs2_addr = bus.i_instr[24:20];

    always_comb begin
        w_dec         = '0;
        w_legal       = 1'b0;
        w_dec.pc      = bus.i_pc;
        w_dec.rd_addr = w_rd;
        case (w_opcode)
            c_opc_op: begin
                w_legal = (w_funct7 == c_f7_zero) ||
                          ((w_funct7 == c_f7_alt) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                w_dec.op = {w_funct7[5], w_funct3};
                w_dec.a  = bus.i_rs1_data;
                w_dec.b  = w_is_shift ? {{(XLEN-5){1'b0}}, bus.i_rs2_data[4:0]}
                                      : bus.i_rs2_data;
            end
            c_opc_op_imm: begin
                w_dec.op = {1'b0, w_funct3};
                w_dec.a  = bus.i_rs1_data;
                w_dec.b  = w_imm_i;
                w_legal  = 1'b1;
                // Shift-immediates reuse imm[11:5] as a funct7 field
                if (w_is_shift) begin
                    w_dec.b = {{(XLEN-5){1'b0}}, bus.i_instr[24:20]};
                    w_legal = (w_funct7 == c_f7_zero) ||
                              ((w_funct7 == c_f7_alt) && (w_funct3 == 3'b101));
                    if (w_funct3 == 3'b101) begin
                        w_dec.op[3] = bus.i_instr[30];
                    end
                end
            end
            c_opc_lui: begin
                w_legal  = 1'b1;
                w_dec.op = c_alu_add;
                w_dec.b  = w_imm_u;
            end
            c_opc_auipc: begin
                w_legal  = 1'b1;
                w_dec.op = c_alu_add;
                w_dec.a  = bus.i_pc;
                w_dec.b  = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec.op = '0;
            w_dec.a  = '0;
            w_dec.b  = '0;
        end
        w_dec.illegal = !w_legal;
        w_dec.rd_we   = w_legal && (w_rd != 5'd0);
    end

`ifdef CPU_DECODE_SKID_EN
    bundle_t r_skid;
    logic    r_skid_valid;

    // Ready comes straight from a flop: no path from i_ready to o_ready
    assign w_ready  = !r_skid_valid;
    assign w_accept = bus.i_valid && w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (bus.i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || bus.i_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign w_ready  = !r_main_valid || bus.i_ready;
    assign w_accept = bus.i_valid && w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (bus.i_flush) begin
            r_main_valid <= 1'b0;
        end else if (w_ready) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main <= w_dec;
            end
        end
    end
`endif

    assign bus.o_ready   = w_ready;
    assign bus.o_valid   = r_main_valid;
    assign bus.o_op      = r_main.op;
    assign bus.o_a       = r_main.a;
    assign bus.o_b       = r_main.b;
    assign bus.o_rd_addr = r_main.rd_addr;
    assign bus.o_rd_we   = r_main.rd_we;
    assign bus.o_pc      = r_main.pc;
    assign bus.o_illegal = r_main.illegal;
endmodule
`default_nettype wire

// File: tb/tb_cpu_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_decode
// Brief    : Directed vector bench for cpu_decode with a small register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_decode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_decode_if #(.XLEN(32)) bus ();
    cpu_decode #(.XLEN(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    logic [31:0] rf [32];
    assign bus.i_rs1_data = rf[bus.o_rs1_addr];
    assign bus.i_rs2_data = rf[bus.o_rs2_addr];

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   idx, got, cyc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add_vec(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic we, input logic ill);
        vec_t v;
        v.nm = nm; v.instr = instr; v.pc = pc; v.op = op; v.a = a; v.b = b;
        v.rd = rd; v.we = we; v.ill = ill;
        vecs.push_back(v);
    endtask

    function automatic logic [127:0] exp_bundle(input vec_t v);
        return {20'b0, 1'b1, v.op, v.a, v.b, v.rd, v.we, v.pc, v.ill};
    endfunction

    // rd of an illegal bundle carries no meaning, so it is not compared
    function automatic logic [127:0] act_bundle(input vec_t v);
        logic [4:0] rd;
        rd = v.ill ? v.rd : bus.o_rd_addr;
        return {20'b0, bus.o_valid, bus.o_op, bus.o_a, bus.o_b, rd, bus.o_rd_we,
                bus.o_pc, bus.o_illegal};
    endfunction

    function automatic logic [127:0] all_outputs();
        return {20'b0, bus.o_valid, bus.o_op, bus.o_a, bus.o_b, bus.o_rd_addr,
                bus.o_rd_we, bus.o_pc, bus.o_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_valid = v;
        bus.i_instr = instr;
        bus.i_pc    = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5; rf[2] = 32'd7; rf[5] = 32'h8000_0010; rf[6] = 32'h25;

        //       name        instr         pc            op     a             b             rd  we ill
        add_vec("add",      32'h002081B3, 32'h0000_0200, 4'h0, 32'd5,        32'd7,        3,  1, 0);
        add_vec("sub",      32'h402081B3, 32'h0000_0204, 4'h8, 32'd5,        32'd7,        3,  1, 0);
        add_vec("srai",     32'h41F2D213, 32'h0000_0208, 4'hD, 32'h80000010, 32'd31,       4,  1, 0);
        add_vec("slli",     32'h00329213, 32'h0000_020C, 4'h1, 32'h80000010, 32'd3,        4,  1, 0);
        add_vec("sll",      32'h00629233, 32'h0000_0210, 4'h1, 32'h80000010, 32'd5,        4,  1, 0);
        add_vec("auipc",    32'h12345397, 32'h0000_0100, 4'h0, 32'h100,      32'h12345000, 7,  1, 0);
        add_vec("lui",      32'hABCDE437, 32'h0000_0218, 4'h0, 32'h0,        32'hABCDE000, 8,  1, 0);
        add_vec("xor",      32'h0020C533, 32'h0000_021C, 4'h4, 32'd5,        32'd7,        10, 1, 0);
        add_vec("ill_zero", 32'h00000000, 32'h0000_0220, 4'h0, 32'h0,        32'h0,        0,  0, 1);
        add_vec("ill_op",   32'h40629233, 32'h0000_0224, 4'h0, 32'h0,        32'h0,        4,  0, 1);
        add_vec("addi_x0",  32'h00100013, 32'h0000_0228, 4'h0, 32'h0,        32'd1,        0,  0, 0);
        add_vec("addi_neg", 32'hFFF08493, 32'h0000_022C, 4'h0, 32'd5,        32'hFFFFFFFF, 9,  1, 0);
        add_vec("ill_slli", 32'h40329213, 32'h0000_0230, 4'h0, 32'h0,        32'h0,        4,  0, 1);
        add_vec("andi",     32'h0F017593, 32'h0000_0234, 4'h7, 32'd7,        32'h000000F0, 11, 1, 0);

        rst = 1'b1; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", all_outputs(), 128'h0);
        chk("reset_ready", 128'(bus.o_ready), 128'h1);

        drive(1'b0, 32'h00629233, 32'h0);
        #1;
        chk("rs_addrs", 128'({bus.o_rs1_addr, bus.o_rs2_addr}), 128'({5'd5, 5'd6}));

        // Back-to-back vectors with i_ready held high
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc);
            #1;
            chk($sformatf("ready_%s", vecs[i].nm), 128'(bus.o_ready), 128'h1);
            tick();
            chk($sformatf("vec_%s", vecs[i].nm), act_bundle(vecs[i]), exp_bundle(vecs[i]));
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", 128'(bus.o_valid), 128'h0);

        // Random backpressure stream with an in-order scoreboard
        idx = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 300) begin
            if (idx < 8) drive(1'b1, vecs[idx].instr, vecs[idx].pc);
            else         drive(1'b0, 32'h0, 32'h0);
            bus.i_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() > 0) begin
                    chk($sformatf("bp_%0d", got), act_bundle(sb[0]), exp_bundle(sb[0]));
                    void'(sb.pop_front());
                end else begin
                    chk("bp_extra", 128'(bus.o_valid), 128'h0);
                end
                got++;
            end
            if (bus.i_valid && bus.o_ready) begin
                sb.push_back(vecs[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        chk("bp_count", 128'(got), 128'd8);
        chk("bp_left", 128'(sb.size()), 128'd0);
        drive(1'b0, 32'h0, 32'h0);
        bus.i_ready = 1'b1;
        tick();

        // Stall: operands held, ready timing, then flush with two entries held
        bus.i_ready = 1'b0;
        drive(1'b1, vecs[0].instr, vecs[0].pc);
        tick();
        drive(1'b1, vecs[6].instr, vecs[6].pc);
        #1;
`ifdef CPU_DECODE_SKID_EN
        chk("stall_ready_first", 128'(bus.o_ready), 128'h1);
`else
        chk("stall_ready_first", 128'(bus.o_ready), 128'h0);
`endif
        rf[1] = 32'd99;
        tick();
        chk("stall_ready_next", 128'(bus.o_ready), 128'h0);
        chk("stall_hold", act_bundle(vecs[0]), exp_bundle(vecs[0]));
        bus.i_flush = 1'b1;
        bus.i_ready = 1'b1;
        drive(1'b1, vecs[7].instr, vecs[7].pc);
        tick();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        rf[1] = 32'd5;
        chk("flush_valid", 128'(bus.o_valid), 128'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("flush_empty_%0d", k), 128'(bus.o_valid), 128'h0);
        end

        // Reset while a bundle is held and another is offered
        bus.i_ready = 1'b0;
        drive(1'b1, vecs[5].instr, vecs[5].pc);
        tick();
        chk("prereset_valid", 128'(bus.o_valid), 128'h1);
        rst = 1'b1;
        drive(1'b1, vecs[1].instr, vecs[1].pc);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("midreset_outputs", all_outputs(), 128'h0);
        chk("midreset_ready", 128'(bus.o_ready), 128'h1);
        bus.i_ready = 1'b1;
        tick();
        chk("postreset_idle", 128'(bus.o_valid), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
